// File: rtl/input_port_pkg.sv
// Shared definitions for the memory-mapped input port.
// Bit positions of the status word and the stat_sel encodings are used by
// the port itself, the bus controller and the assembler, so they live here.
package input_port_pkg;

    localparam int BUS_W = 16;

    // Status word layout
    localparam int STAT_READY_BIT   = 0;
    localparam int STAT_OVERRUN_BIT = 1;

    // stat_sel encodings
    localparam logic INPORT_DATA_SEL = 1'b0;
    localparam logic INPORT_STAT_SEL = 1'b1;

    // Controller-side read request as seen by the port
    typedef struct packed {
        logic en;
        logic sel;
    } inport_req_t;

    // Flags held by the port
    typedef struct packed {
        logic overrun;
        logic ready;
    } inport_flags_t;

    // Pack the flags into a bus-width status word
    function automatic logic [BUS_W-1:0] stat_word(input inport_flags_t f);
        logic [BUS_W-1:0] w;
        w = '0;
        w[STAT_READY_BIT]   = f.ready;
        w[STAT_OVERRUN_BIT] = f.overrun;
        return w;
    endfunction

endpackage

// File: rtl/input_port_debouncer.sv
// Pin synchronizer and debouncer for the input port.
// Ports:
//   clk, rst     - system clock, asynchronous active-low reset
//   in           - raw asynchronous pins
//   stable       - last accepted debounced value
//   accept       - high for the single cycle before stable takes a new value
module input_debouncer
    import input_port_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] stable,
    output logic             accept
);

    localparam int             CNT_W   = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;

    // Accept only once cand has held long enough and actually differs;
    // after the update cand == stable, so this is a one-cycle pulse.
    assign accept = (cnt == CNT_MAX) && (cand != stable);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= '0;
            sync2  <= '0;
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                stable <= cand;
            end
        end
    end

endmodule

// File: rtl/input_port.sv
// Memory-mapped input port: debounced IN pins read over the 16-bit bus.
// Ports:
//   clk, rst   - 1 MHz system clock, asynchronous active-low reset
//   in         - raw WIDTH-bit pins
//   out_en     - controller read strobe; out is driven only while high
//   stat_sel   - 0 selects data, 1 selects status {overrun, ready}
//   out        - bus read data, zero when out_en is low
//   ready      - a new stable value is waiting to be read
module input_port
    import input_port_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             out_en,
    input  logic             stat_sel,
    output logic [BUS_W-1:0] out,
    output logic             ready
);

    logic [WIDTH-1:0] stable;
    logic             accept;
    inport_req_t      req;
    inport_flags_t    flags;
    logic             data_rd;
    logic             stat_rd;

    input_debouncer #(
        .WIDTH    (WIDTH),
        .DEBOUNCE (DEBOUNCE)
    ) u_deb (
        .clk    (clk),
        .rst    (rst),
        .in     (in),
        .stable (stable),
        .accept (accept)
    );

    assign req     = '{en: out_en, sel: stat_sel};
    assign data_rd = req.en && (req.sel == INPORT_DATA_SEL);
    assign stat_rd = req.en && (req.sel == INPORT_STAT_SEL);
    assign ready   = flags.ready;

    // A new value always wins over a clearing read. Overrun is only raised
    // when the previous value was not consumed on this same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags <= '0;
        end else begin
            if (accept && flags.ready && !data_rd) begin
                flags.overrun <= 1'b1;
            end else if (stat_rd) begin
                flags.overrun <= 1'b0;
            end
            if (accept) begin
                flags.ready <= 1'b1;
            end else if (data_rd) begin
                flags.ready <= 1'b0;
            end
        end
    end

    always_comb begin
        out = '0;
        if (req.en) begin
            if (req.sel == INPORT_STAT_SEL) begin
                out = stat_word(flags);
            end else begin
                out = BUS_W'(stable);
            end
        end
    end

endmodule

// File: tb/tb_input_port.sv
// Randomized and directed bench for input_port with DEBOUNCE=4.
// Reference model: a new value v is accepted on edge k when the pin samples
// taken on edges k-D-3 .. k-3 all equal v and v differs from the held value.
module tb_input_port;

    localparam int D = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  pins;
    logic        out_en;
    logic        stat_sel;
    logic [15:0] out;
    logic        ready;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic [7:0] h_q[$];     // h_q[i] = pins sampled i+1 edges ago
    logic [7:0] m_stable;
    logic       m_rdy;
    logic       m_ov;

    input_port #(.WIDTH(8), .DEBOUNCE(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (pins),
        .out_en   (out_en),
        .stat_sel (stat_sel),
        .out      (out),
        .ready    (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_out();
        if (!out_en) return 16'h0000;
        if (stat_sel) return {14'b0, m_ov, m_rdy};
        return {8'h00, m_stable};
    endfunction

    task automatic model_reset();
        h_q.delete();
        repeat (D + 3) h_q.push_back(8'h00);
        m_stable = 8'h00;
        m_rdy    = 1'b0;
        m_ov     = 1'b0;
    endtask

    // One rising edge with the current inputs; model advance and check.
    task automatic tick();
        logic       win;
        logic       acc;
        logic       drd;
        logic       srd;
        logic [7:0] v;
        logic [7:0] p;
        v   = h_q[2];
        win = 1'b1;
        for (int i = 2; i <= D + 2; i++) if (h_q[i] != v) win = 1'b0;
        acc = win && (v != m_stable);
        drd = out_en && !stat_sel;
        srd = out_en && stat_sel;
        p   = pins;
        @(posedge clk);
        #1;
        if (acc && m_rdy && !drd) m_ov = 1'b1;
        else if (srd)             m_ov = 1'b0;
        if (acc)      m_rdy = 1'b1;
        else if (drd) m_rdy = 1'b0;
        if (acc) m_stable = v;
        h_q.push_front(p);
        void'(h_q.pop_back());
        chk("out", out, exp_out());
        chk("ready", {15'b0, ready}, {15'b0, m_rdy});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_out", out, 16'h0000);
        chk("rst_ready", {15'b0, ready}, 16'h0000);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_out_hold", out, 16'h0000);
            chk("rst_ready_hold", {15'b0, ready}, 16'h0000);
        end
        rst = 1'b1;
    endtask

    task automatic settle(input logic [7:0] v);
        out_en = 1'b0;
        pins   = v;
        repeat (D + 4) tick();
        out_en = 1'b1; stat_sel = 1'b0;
        tick();
        out_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pins = 8'hFF; out_en = 1'b0; stat_sel = 1'b0;
        model_reset();
        #2;

        // Reset with pins high, reads forced to zero during reset
        out_en = 1'b1;
        do_reset();
        stat_sel = 1'b0;
        repeat (D + 3) begin
            tick();
            chk("rst_stable0", out, 16'h0000);
        end
        tick();
        chk("rst_accept_ready", {15'b0, ready}, 16'h0001);
        chk("rst_accept_data", out, 16'h00FF);
        tick();
        chk("rst_read_clr", {15'b0, ready}, 16'h0000);
        out_en = 1'b0;

        // Clean change 00 -> A5
        settle(8'h00);
        pins = 8'hA5;
        repeat (D + 3) tick();
        chk("clean_early", {15'b0, ready}, 16'h0000);
        tick();
        chk("clean_edge8", {15'b0, ready}, 16'h0001);
        out_en = 1'b1; stat_sel = 1'b0;
        #1;
        chk("clean_data", out, 16'h00A5);
        tick();
        chk("clean_clr", {15'b0, ready}, 16'h0000);
        out_en = 1'b0;

        // Glitch
        settle(8'h00);
        pins = 8'h3C;
        repeat (3) tick();
        pins = 8'h00;
        repeat (10) tick();
        chk("glitch_ready", {15'b0, ready}, 16'h0000);
        out_en = 1'b1; stat_sel = 1'b0;
        #1;
        chk("glitch_data", out, 16'h0000);
        tick();
        out_en = 1'b0;

        // Overrun
        pins = 8'h11;
        repeat (D + 4) tick();
        pins = 8'h22;
        repeat (D + 4) tick();
        out_en = 1'b1; stat_sel = 1'b1;
        #1;
        chk("ovr_stat1", out, 16'h0003);
        tick();
        chk("ovr_stat2", out, 16'h0001);
        tick();
        stat_sel = 1'b0;
        #1;
        chk("ovr_data", out, 16'h0022);
        tick();
        chk("ovr_clr", {15'b0, ready}, 16'h0000);
        out_en = 1'b0;

        // Collision: data read held across the accept edge
        pins = 8'h55;
        out_en = 1'b1; stat_sel = 1'b0;
        repeat (D + 4) tick();
        stat_sel = 1'b1;
        #1;
        chk("coll_stat", out, 16'h0001);
        stat_sel = 1'b0;
        #1;
        chk("coll_data", out, 16'h0055);
        tick();
        chk("coll_clr", {15'b0, ready}, 16'h0000);
        out_en = 1'b0;

        // Bus idle with stable = FF
        pins = 8'hFF;
        repeat (2 * D + 8) begin
            stat_sel = 1'($urandom);
            tick();
            chk("idle_out", out, 16'h0000);
        end

        // Reset mid-debounce discards the pending value
        pins = 8'h77;
        repeat (4) tick();
        do_reset();
        pins = 8'h00;
        repeat (10) tick();
        chk("mid_rst_ready", {15'b0, ready}, 16'h0000);

        // Random pins with random hold lengths and random reads
        repeat (150) begin
            int hold;
            pins = 8'($urandom);
            hold = $urandom_range(1, 12);
            repeat (hold) begin
                out_en   = ($urandom_range(0, 3) == 0);
                stat_sel = 1'($urandom);
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/input_port.md
Name: input_port

Overview:
- Memory-mapped input peripheral: the pins-to-bus counterpart of the display block, which drives the bus onto the OUT pins.
- Samples the 8-bit IN pins, synchronizes and debounces them, and latches each new stable value.
- Flags the latched value for the controller and drives it onto the 16-bit bus when the controller enables the port.
- Runs on the divided 1 MHz system clock.

Parameters:
- WIDTH, 8: number of input pins.
- DEBOUNCE, 16: consecutive stable cycles required before a new value is accepted (>=1).

Ports:
- clk  input  1  system clock (1 MHz domain).
- rst  input  1  asynchronous, active-low reset.
- in  input  WIDTH  raw asynchronous pin values.
- out_en  input  1  controller read strobe; this block drives out while high.
- stat_sel  input  1  0 = data read, 1 = status read; only meaningful while out_en is high.
- out  output  16  bus read data; all zeros when out_en is low.
- ready  output  1  new stable value waiting to be read (status bit 0).

Behaviour:
- Reset: rst low immediately clears sync1, sync2, cand, cnt, stable, ready and overrun to 0, and forces out to 0. The block leaves reset on the first rising clk edge with rst high. Reset asserted mid-debounce discards the pending value.
- Synchronizer: two flops, sync1 <= in and sync2 <= sync1, every edge.
- Debounce:
  - sync2 != cand: cand <= sync2, cnt <= 0.
  - Else, cnt < DEBOUNCE: cnt <= cnt+1.
  - Else: cnt saturates at DEBOUNCE.
  - cnt width is clog2(DEBOUNCE+1).
- Accept: on an edge where cnt == DEBOUNCE and cand != stable, stable <= cand and ready <= 1.
  - If ready was already 1 on that edge, overrun <= 1; the older value is lost.
- Latency: a clean pin change reaching stable takes DEBOUNCE+4 rising edges, counting the first edge after the change as edge 1. With DEBOUNCE=4, stable updates on edge 8.
- Glitches: a pulse that reverts before cnt reaches DEBOUNCE never reaches stable. An equal value is never re-accepted.
- Read mux (combinational):
  - out_en=1, stat_sel=0: out = {(16-WIDTH) zeros, stable}.
  - out_en=1, stat_sel=1: out = {14'b0, overrun, ready}.
  - out_en=0: out = 16'h0000.
- Data read side effect: on each edge with out_en=1 and stat_sel=0, ready <= 0.
- Status read side effect: on each edge with out_en=1 and stat_sel=1, overrun <= 0. ready is unchanged.
- Simultaneous accept and data read on the same edge: the set wins, so ready stays 1. overrun is not set, because the read consumed the old value.
- Simultaneous accept-with-overrun and status read on the same edge: the set wins, so overrun stays 1.
- A read held for multiple cycles repeats its side effect each edge. The bus value follows stable combinationally.

Decomposition:
- Shared package constants:
  - STAT_READY_BIT = 0.
  - STAT_OVERRUN_BIT = 1.
  - INPORT_DATA_SEL = 1'b0.
  - INPORT_STAT_SEL = 1'b1.
- Controller and assembler reuse these constants.
- One sub-module, input_debouncer: holds the synchronizer, cand, cnt and stable. It outputs stable plus a one-cycle accept pulse.
- input_port itself holds the ready/overrun flags and the read mux.

Test Plan (DEBOUNCE=4 in the bench):
- Reset:
  - Stimulus: rst low with in=8'hFF, then release.
  - Required: out=0 and ready=0 throughout reset. stable stays 0 until 8 edges after release.
- Clean change:
  - Stimulus: in 8'h00 -> 8'hA5, then hold.
  - Required: ready rises on edge 8. A data read returns 16'h00A5, and ready=0 after that edge.
- Glitch:
  - Stimulus: in = 8'h3C for 3 cycles, then back to 8'h00.
  - Required: ready stays 0 and a data read returns 16'h0000.
- Overrun:
  - Stimulus: accept 8'h11, then 8'h22, with no read in between.
  - Required: status read returns 16'h0003 and the following status read returns 16'h0001. Data read returns 16'h0022.
- Collision:
  - Stimulus: data read held across the accept edge of 8'h55.
  - Required: ready=1 and overrun=0 after that edge. The next data read returns 16'h0055 and clears ready.
- Bus idle:
  - Stimulus: out_en=0 with stable=8'hFF.
  - Required: out=16'h0000 on every cycle.
